// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle control unit.
//   state_t    - 3-bit controller state (IF..ERR)
//   op_t       - priority-resolved instruction class
//   ALUC_*     - ALU operation codes (zero-extended to ALUC_W at the port)
//   PC_*/A_*/B_* - PC_Sel / ALU_A_Sel / ALU_B_Sel mux encodings
//   decode_op  - collapses the one-hot opcode flags into op_t using the
//                fixed instruction priority
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_BR  = 3'd5,
        S_ERR = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
        OP_ADDU, OP_SUBU, OP_ORI, OP_SLL
    } op_t;

    localparam logic [1:0] ALUC_ADD = 2'd0;
    localparam logic [1:0] ALUC_SUB = 2'd1;
    localparam logic [1:0] ALUC_OR  = 2'd2;
    localparam logic [1:0] ALUC_SLL = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_RS    = 2'b01;
    localparam logic [1:0] A_SHAMT = 2'b10;

    localparam logic [1:0] B_RT      = 2'b00;
    localparam logic [1:0] B_FOUR    = 2'b01;
    localparam logic [1:0] B_IMM     = 2'b10;
    localparam logic [1:0] B_IMM_SL2 = 2'b11;

    // If the decoder ever raises more than one flag, the highest-priority
    // instruction wins and every later state decodes that same instruction.
    function automatic op_t decode_op(input logic lw, input logic sw,
                                      input logic beq, input logic bne,
                                      input logic j_i, input logic addu,
                                      input logic subu, input logic ori,
                                      input logic sll);
        op_t op;
        if (lw)        op = OP_LW;
        else if (sw)   op = OP_SW;
        else if (beq)  op = OP_BEQ;
        else if (bne)  op = OP_BNE;
        else if (j_i)  op = OP_J;
        else if (addu) op = OP_ADDU;
        else if (subu) op = OP_SUBU;
        else if (ori)  op = OP_ORI;
        else if (sll)  op = OP_SLL;
        else           op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the controller, the instruction decoder and
// the datapath/memories.
//   inputs to controller : zero, im_ready, dm_ready, one-hot opcode flags
//   outputs of controller: register write enables, mux selects, ALUC,
//                          memory strobes, retire, err, state_o
//   modport master = controller side, slave = decoder/datapath side.
interface mc_ctrl_if #(parameter int ALUC_W = 3);
    logic              zero, im_ready, dm_ready;
    logic              addu, subu, ori, sll, lw, sw, beq, bne, j_i;
    logic              PC_W, IR_W, RF_W, ALUOut_W;
    logic [1:0]        PC_Sel, ALU_A_Sel, ALU_B_Sel;
    logic [ALUC_W-1:0] ALUC;
    logic              MemtoReg, sign_ext, IM_R, DM_R, DM_W, DM_CS;
    logic              retire, err;
    logic [2:0]        state_o;

    modport master (
        input  zero, im_ready, dm_ready,
               addu, subu, ori, sll, lw, sw, beq, bne, j_i,
        output PC_W, IR_W, RF_W, ALUOut_W, PC_Sel, ALU_A_Sel, ALU_B_Sel,
               ALUC, MemtoReg, sign_ext, IM_R, DM_R, DM_W, DM_CS,
               retire, err, state_o
    );

    modport slave (
        output zero, im_ready, dm_ready,
               addu, subu, ori, sll, lw, sw, beq, bne, j_i,
        input  PC_W, IR_W, RF_W, ALUOut_W, PC_Sel, ALU_A_Sel, ALU_B_Sel,
               ALUC, MemtoReg, sign_ext, IM_R, DM_R, DM_W, DM_CS,
               retire, err, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU controller (IF/ID/EX/MEM/WB/BR/ERR).
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; parks the FSM in IF
//   bus    - mc_ctrl_if.master: decoder flags and memory readies in,
//            datapath enables/selects, retire pulse, err, state_o out
// Parameters: ALUC_W (ALU control width), MAX_WAIT (wait-cycle limit).
// Build option: define MC_CTRL_TIMEOUT_EN to add the per-access wait
// counter that traps to ERR after MAX_WAIT consecutive not-ready cycles.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUC_W   = 3,
    parameter int MAX_WAIT = 16
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    state_t     state_q, state_d;
    op_t        op;
    logic       pc_w, ir_w, rf_w, aluout_w;
    logic [1:0] pc_sel, a_sel, b_sel, aluc;
    logic       memtoreg, sign_ext, im_r, dm_r, dm_w, dm_cs, retire;

    assign op = decode_op(bus.lw, bus.sw, bus.beq, bus.bne, bus.j_i,
                          bus.addu, bus.subu, bus.ori, bus.sll);

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             waiting;

    assign waiting = (state_q == S_IF  && !bus.im_ready) ||
                     (state_q == S_MEM && !bus.dm_ready);

    // Counts only consecutive stalls of one access: any transition wipes it.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end

    assign bus.err = (state_q == S_ERR);
`else
    localparam int unused_max_wait = MAX_WAIT;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_w     = 1'b0;
        ir_w     = 1'b0;
        rf_w     = 1'b0;
        aluout_w = 1'b0;
        pc_sel   = PC_ALU;
        a_sel    = A_PC;
        b_sel    = B_RT;
        aluc     = ALUC_ADD;
        memtoreg = 1'b0;
        sign_ext = 1'b0;
        im_r     = 1'b0;
        dm_r     = 1'b0;
        dm_w     = 1'b0;
        dm_cs    = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            S_IF: begin
                // PC+4 is computed every IF cycle; it only lands with the IR.
                im_r  = 1'b1;
                b_sel = B_FOUR;
                if (bus.im_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // Branch target PC+(imm<<2) is parked in ALUOut for BR.
                b_sel    = B_IMM_SL2;
                sign_ext = 1'b1;
                aluout_w = 1'b1;
                unique case (op)
                    OP_J: begin
                        pc_w    = 1'b1;
                        pc_sel  = PC_JUMP;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_NONE:        state_d = S_IF;
                    default:        state_d = S_EX;
                endcase
            end
            S_EX: begin
                aluout_w = 1'b1;
                a_sel    = (op == OP_SLL) ? A_SHAMT : A_RS;
                unique case (op)
                    OP_SUBU: aluc = ALUC_SUB;
                    OP_ORI: begin
                        b_sel = B_IMM;
                        aluc  = ALUC_OR;
                    end
                    OP_SLL: aluc = ALUC_SLL;
                    OP_LW, OP_SW: begin
                        b_sel    = B_IMM;
                        sign_ext = 1'b1;
                    end
                    default: ;
                endcase
                state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dm_cs = 1'b1;
                dm_r  = (op == OP_LW);
                dm_w  = (op == OP_SW);
                if (bus.dm_ready) begin
                    if (op == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                rf_w     = 1'b1;
                memtoreg = (op == OP_LW);
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_BR: begin
                a_sel   = A_RS;
                aluc    = ALUC_SUB;
                pc_sel  = PC_ALUOUT;
                pc_w    = (op == OP_BEQ) ? bus.zero : !bus.zero;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IF;
        endcase

`ifdef MC_CTRL_TIMEOUT_EN
        if (waiting && wait_q == CNT_W'(MAX_WAIT - 1)) state_d = S_ERR;
`endif

        // Nothing architectural may be written while reset is held.
        if (reset) begin
            pc_w     = 1'b0;
            ir_w     = 1'b0;
            rf_w     = 1'b0;
            aluout_w = 1'b0;
            dm_w     = 1'b0;
            retire   = 1'b0;
        end
    end

    assign bus.PC_W      = pc_w;
    assign bus.IR_W      = ir_w;
    assign bus.RF_W      = rf_w;
    assign bus.ALUOut_W  = aluout_w;
    assign bus.PC_Sel    = pc_sel;
    assign bus.ALU_A_Sel = a_sel;
    assign bus.ALU_B_Sel = b_sel;
    assign bus.ALUC      = ALUC_W'(aluc);
    assign bus.MemtoReg  = memtoreg;
    assign bus.sign_ext  = sign_ext;
    assign bus.IM_R      = im_r;
    assign bus.DM_R      = dm_r;
    assign bus.DM_W      = dm_w;
    assign bus.DM_CS     = dm_cs;
    assign bus.retire    = retire;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm.
// The driver builds each random instruction's expected behaviour (state
// trace, per-signal active-cycle counts, EX controls, retire-cycle controls)
// from the instruction table and pushes it; a negedge monitor accumulates
// what the DUT does and compares on every retire pulse.
module tb_mc_ctrl_fsm;

    localparam int ALUC_W   = 3;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUC_W(ALUC_W)) bus();

    mc_ctrl_fsm #(.ALUC_W(ALUC_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lat, imr, irw, dmcs, dmr, dmw, aow, pcw, rfw;
        logic [63:0] trace;
        logic        has_ex;
        logic [7:0]  exsig;
        logic [1:0]  pcsel;
        logic        m2r, dmw_ret;
    } exp_t;

    exp_t q[$];
    int   pushed  = 0;
    int   retired = 0;

    // ---------------- monitor ----------------
    int          m_lat, m_imr, m_irw, m_dmcs, m_dmr, m_dmw, m_aow, m_pcw, m_rfw;
    logic [63:0] m_trace;
    logic [7:0]  m_ex;
    logic        m_saw_ex;

    task automatic mclr();
        m_lat = 0; m_imr = 0; m_irw = 0; m_dmcs = 0; m_dmr = 0; m_dmw = 0;
        m_aow = 0; m_pcw = 0; m_rfw = 0; m_trace = '0; m_ex = '0; m_saw_ex = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mclr();
        end else begin
            m_lat++;
            m_trace = {m_trace[60:0], bus.state_o};
            m_imr  += int'(bus.IM_R);
            m_irw  += int'(bus.IR_W);
            m_dmcs += int'(bus.DM_CS);
            m_dmr  += int'(bus.DM_R);
            m_dmw  += int'(bus.DM_W);
            m_aow  += int'(bus.ALUOut_W);
            m_pcw  += int'(bus.PC_W);
            m_rfw  += int'(bus.RF_W);
            if (bus.state_o == 3'd2) begin
                m_ex     = {bus.ALU_A_Sel, bus.ALU_B_Sel, bus.ALUC, bus.sign_ext};
                m_saw_ex = 1'b1;
            end
            if (bus.retire) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retire=1 expected no retire (state %0d)", bus.state_o);
                end else begin
                    e = q.pop_front();
                    retired++;
                    chk("latency",   m_lat,    e.lat);
                    chk("trace",     m_trace,  e.trace);
                    chk("IM_R_cyc",  m_imr,    e.imr);
                    chk("IR_W_cyc",  m_irw,    e.irw);
                    chk("DM_CS_cyc", m_dmcs,   e.dmcs);
                    chk("DM_R_cyc",  m_dmr,    e.dmr);
                    chk("DM_W_cyc",  m_dmw,    e.dmw);
                    chk("ALUOut_W",  m_aow,    e.aow);
                    chk("PC_W_cyc",  m_pcw,    e.pcw);
                    chk("RF_W_cyc",  m_rfw,    e.rfw);
                    chk("saw_EX",    m_saw_ex, e.has_ex);
                    if (e.has_ex) chk("EX_ctrl", m_ex, e.exsig);
                    chk("PC_Sel_ret",   bus.PC_Sel,   e.pcsel);
                    chk("MemtoReg_ret", bus.MemtoReg, e.m2r);
                    chk("DM_W_ret",     bus.DM_W,     e.dmw_ret);
                end
                mclr();
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_flags(input logic [8:0] f);
        {bus.lw, bus.sw, bus.beq, bus.bne, bus.j_i,
         bus.addu, bus.subu, bus.ori, bus.sll} = f;
    endtask

    task automatic step(input logic im, input logic dm, input logic z);
        bus.im_ready = im;
        bus.dm_ready = dm;
        bus.zero     = z;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic exp_t add_state(input exp_t e, input int st);
        exp_t r = e;
        r.trace = {r.trace[60:0], 3'(st)};
        r.lat++;
        return r;
    endfunction

    // Flag bit positions, highest priority first: lw sw beq bne j addu subu ori sll
    localparam int F_LW = 8, F_SW = 7, F_BEQ = 6, F_BNE = 5, F_J = 4,
                   F_ADDU = 3, F_SUBU = 2, F_ORI = 1, F_SLL = 0;

    exp_t carry;

    task automatic run_instr(input logic [8:0] f, input int iw, input int dw, input logic z);
        exp_t e = carry;
        int   w = -1;
        logic is_alu, is_mem, taken;
        for (int b = 0; b < 9; b++) if (f[b]) w = b;
        is_alu = (w == F_ADDU || w == F_SUBU || w == F_ORI || w == F_SLL);
        is_mem = (w == F_LW || w == F_SW);
        taken  = (w == F_BEQ) ? z : !z;

        for (int k = 0; k <= iw; k++) e = add_state(e, 0);
        e = add_state(e, 1);
        e.imr += iw + 1; e.irw += 1; e.pcw += 1; e.aow += 1;
        e.has_ex = is_alu || is_mem;
        e.pcsel = 2'b00; e.m2r = 1'b0; e.dmw_ret = 1'b0; e.exsig = '0;
        if (w == F_J) begin
            e.pcw += 1; e.pcsel = 2'b10;
        end else if (w == F_BEQ || w == F_BNE) begin
            e = add_state(e, 5);
            e.pcsel = 2'b01;
            if (taken) e.pcw += 1;
        end else if (w >= 0) begin
            e = add_state(e, 2);
            e.aow += 1;
            case (w)
                F_ADDU: e.exsig = {2'b01, 2'b00, 3'd0, 1'b0};
                F_SUBU: e.exsig = {2'b01, 2'b00, 3'd1, 1'b0};
                F_ORI:  e.exsig = {2'b01, 2'b10, 3'd2, 1'b0};
                F_SLL:  e.exsig = {2'b10, 2'b00, 3'd3, 1'b0};
                default: e.exsig = {2'b01, 2'b10, 3'd0, 1'b1};
            endcase
            if (is_mem) begin
                for (int k = 0; k <= dw; k++) e = add_state(e, 3);
                e.dmcs += dw + 1;
                if (w == F_LW) e.dmr += dw + 1;
                else begin e.dmw += dw + 1; e.dmw_ret = 1'b1; end
            end
            if (w != F_SW) begin
                e = add_state(e, 4);
                e.rfw += 1;
                e.m2r = (w == F_LW);
            end
        end

        if (w < 0) begin
            carry = e;          // no retire: its cycles roll into the next one
        end else begin
            q.push_back(e);
            pushed++;
            carry = '{default: 0};
        end

        set_flags(f);
        for (int k = 0; k < iw; k++) step(1'b0, rb(), rb());
        step(1'b1, rb(), rb());                       // IF completes
        step(rb(), rb(), rb());                       // ID
        if (w == F_BEQ || w == F_BNE) step(rb(), rb(), z);
        else if (w >= 0 && w != F_J) begin
            step(rb(), rb(), rb());                   // EX
            if (is_mem) begin
                for (int k = 0; k < dw; k++) step(rb(), 1'b0, rb());
                step(rb(), 1'b1, rb());
            end
            if (w != F_SW) step(rb(), rb(), rb());    // WB
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] f;
        logic       prev_none;
        int         pick, w;

        carry = '{default: 0};
        set_flags('0);
        bus.im_ready = 1'b0; bus.dm_ready = 1'b0; bus.zero = 1'b0;

        // Reset: enables forced low even with a fetch ready and a jump decoded.
        @(posedge clk); #1;
        bus.im_ready = 1'b1;
        set_flags(9'b1 << F_J);
        #1;
        chk("reset_enables", {bus.PC_W, bus.IR_W, bus.RF_W, bus.ALUOut_W, bus.DM_W, bus.retire}, 6'b0);
        chk("reset_state_in", bus.state_o, 3'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.im_ready = 1'b0;
        set_flags('0);
        #1;
        chk("reset_state", bus.state_o, 3'd0);
        chk("reset_err", bus.err, 1'b0);

`ifdef MC_CTRL_TIMEOUT_EN
        for (int k = 0; k < MAX_WAIT; k++) begin
            bus.im_ready = 1'b0;
            #1;
            chk("timeout_wait_IF", bus.state_o, 3'd0);
            @(posedge clk); #1;
        end
        #1;
        chk("timeout_state_ERR", bus.state_o, 3'd6);
        chk("timeout_err", bus.err, 1'b1);
        chk("timeout_enables", {bus.IM_R, bus.PC_W, bus.IR_W, bus.retire}, 4'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("timeout_reset_state", bus.state_o, 3'd0);
        chk("timeout_reset_err", bus.err, 1'b0);
`endif

        // Reset in MEM of a store: the store is abandoned and never retires.
        set_flags(9'b1 << F_SW);
        step(1'b1, 1'b0, 1'b0);   // IF
        step(1'b0, 1'b0, 1'b0);   // ID
        step(1'b0, 1'b0, 1'b0);   // EX
        bus.dm_ready = 1'b0;
        #1;
        chk("sw_mem_state", bus.state_o, 3'd3);
        chk("sw_mem_DM_W", bus.DM_W, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("sw_reset_DM_W", bus.DM_W, 1'b0);
        chk("sw_reset_retire", bus.retire, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_flags('0);
        #1;
        chk("sw_after_reset_state", bus.state_o, 3'd0);

        // Random instruction stream.
        prev_none = 1'b1;
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 12);
            if (pick <= 8) begin
                f = 9'b1 << pick;
            end else if (pick == 9 && !prev_none) begin
                f = '0;
            end else begin
                // Several flags at once; the store flag is kept out of these.
                case ($urandom_range(0, 6))
                    0: w = F_LW;  1: w = F_BEQ;  2: w = F_BNE;  3: w = F_J;
                    4: w = F_ADDU; 5: w = F_SUBU; default: w = F_ORI;
                endcase
                f = (9'b1 << w) | (9'($urandom) & ((9'b1 << w) - 9'd1));
                f[F_SW] = 1'b0;
            end
            prev_none = (f == '0);
            run_instr(f, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
        if (prev_none) run_instr(9'b1 << F_ADDU, 0, 0, 1'b0);

        set_flags('0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        chk("queue_drained", q.size(), 0);
        chk("retire_count", retired, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
